// File: rtl/battleship_pkg.sv
// -----------------------------------------------------------------------------
// battleship_pkg
// Definitions shared by the BattleShip phase sequencer, board and drawer blocks.
//   phase_t             : game phase encoding
//   DEFAULT_NUM_PLAYERS : default number of players taking turns
//   DEFAULT_NUM_SHIPS   : default number of ships each player places
// -----------------------------------------------------------------------------
package battleship_pkg;

    typedef enum logic [1:0] {
        WELCOME = 2'b00,
        PLACE   = 2'b01,
        PLAY    = 2'b10,
        OVER    = 2'b11
    } phase_t;

    localparam int DEFAULT_NUM_PLAYERS = 2;
    localparam int DEFAULT_NUM_SHIPS   = 5;

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Turns the raw active-low push-button into a single-cycle press pulse:
// 2-flop synchroniser, optional debounce filter, falling-edge detector.
//
// Build option:
//   KEY_DEBOUNCE_EN defined   : the synchronised level must hold a new value
//                               for DEBOUNCE_CYCLES consecutive cycles before
//                               the edge detector sees it.
//   KEY_DEBOUNCE_EN undefined : the synchroniser output feeds the edge
//                               detector directly; DEBOUNCE_CYCLES is unused.
//
// Ports:
//   clk   in  system clock, rising edge
//   rstN  in  asynchronous active-low reset
//   keyN  in  raw key level, active-low, asynchronous to clk
//   press out one-cycle pulse per press (high-to-low transition)
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rstN,
    input  logic keyN,
    output logic press
);

    logic syncMeta;
    logic syncOut;
    logic levelNow;
    logic levelDly;

    // Idle level of the key is high, so every stage resets to 1 and the
    // release of reset can never look like a press.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            syncMeta <= 1'b1;
            syncOut  <= 1'b1;
        end else begin
            syncMeta <= keyN;
            syncOut  <= syncMeta;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(DEBOUNCE_CYCLES - 1);

    logic [CntW-1:0] stableCnt;
    logic            stableLvl;

    // Down-counter reloads whenever the input agrees with the accepted level;
    // terminal count (0) on a differing sample means DEBOUNCE_CYCLES
    // consecutive differing samples were seen. It stops there, never wraps.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stableCnt <= CntLoad;
            stableLvl <= 1'b1;
        end else if (syncOut == stableLvl) begin
            stableCnt <= CntLoad;
        end else if (stableCnt == '0) begin
            stableLvl <= syncOut;
            stableCnt <= CntLoad;
        end else begin
            stableCnt <= stableCnt - 1'b1;
        end
    end

    assign levelNow = stableLvl;
`else
    assign levelNow = syncOut;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            levelDly <= 1'b1;
        end else begin
            levelDly <= levelNow;
        end
    end

    assign press = levelDly & ~levelNow;

endmodule

// File: rtl/game_phase_fsm.sv
// -----------------------------------------------------------------------------
// game_phase_fsm
// BattleShip phase sequencer: welcome screen, per-player ship placement,
// alternating turns, game over. Every state entry (and every player change)
// requests one redraw from the VGA drawer; game events are dropped while a
// draw is pending or in progress.
//
// Build option: KEY_DEBOUNCE_EN enables the advance-key debounce filter
// inside key_debounce (DEBOUNCE_CYCLES stable cycles required).
//
// Parameters: NUM_PLAYERS (>=2), NUM_SHIPS (>=1), DEBOUNCE_CYCLES
// Ports:
//   CLOCK_50     in  system clock, rising edge
//   resetn       in  asynchronous active-low reset
//   advance_n    in  raw KEY, active-low, asynchronous
//   ship_placed  in  pulse, current player committed a ship
//   shot_fired   in  pulse, current player fired
//   all_sunk     in  level, marks shot_fired as the winning shot
//   draw_done    in  pulse, drawer finished the requested screen
//   draw_welcome out phase flag WELCOME
//   place_ships  out phase flag PLACE
//   start_game   out phase flag PLAY
//   game_over    out phase flag OVER
//   player       out current player (winner in OVER)
//   ships_left   out ships still to place for the current player
//   draw_req     out one-cycle pulse, render the current phase
//
// State table:
//   WELCOME | welcome screen, waiting for an advance press
//   PLACE   | players place their fleets in turn
//   PLAY    | players fire in turn until a winning shot
//   OVER    | winner shown, waiting for an advance press
// -----------------------------------------------------------------------------
module game_phase_fsm
    import battleship_pkg::*;
#(
    parameter int NUM_PLAYERS     = DEFAULT_NUM_PLAYERS,
    parameter int NUM_SHIPS       = DEFAULT_NUM_SHIPS,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                           CLOCK_50,
    input  logic                           resetn,
    input  logic                           advance_n,
    input  logic                           ship_placed,
    input  logic                           shot_fired,
    input  logic                           all_sunk,
    input  logic                           draw_done,
    output logic                           draw_welcome,
    output logic                           place_ships,
    output logic                           start_game,
    output logic                           game_over,
    output logic [$clog2(NUM_PLAYERS)-1:0] player,
    output logic [$clog2(NUM_SHIPS+1)-1:0] ships_left,
    output logic                           draw_req
);

    localparam int PlayerW = $clog2(NUM_PLAYERS);
    localparam int ShipsW  = $clog2(NUM_SHIPS + 1);
    localparam logic [PlayerW-1:0] LastPlayer = PlayerW'(NUM_PLAYERS - 1);
    localparam logic [ShipsW-1:0]  FullFleet  = ShipsW'(NUM_SHIPS);

    phase_t             stateReg,  stateNext;
    logic [PlayerW-1:0] playerReg, playerNext;
    logic [ShipsW-1:0]  shipsReg,  shipsNext;
    logic               pendReg,   pendNext;
    logic               busyReg,   busyNext;
    logic               drawReqReg;
    logic               press;
    logic               idle;
    logic               redraw;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uKeyDebounce (
        .clk  (CLOCK_50),
        .rstN (resetn),
        .keyN (advance_n),
        .press(press)
    );

    // Reset leaves pend set so the welcome screen is drawn right after release.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            stateReg   <= WELCOME;
            playerReg  <= '0;
            shipsReg   <= FullFleet;
            pendReg    <= 1'b1;
            busyReg    <= 1'b0;
            drawReqReg <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            playerReg  <= playerNext;
            shipsReg   <= shipsNext;
            pendReg    <= pendNext;
            busyReg    <= busyNext;
            drawReqReg <= pendReg;
        end
    end

    // Events only count once the drawer has caught up with the screen.
    assign idle = !pendReg && !busyReg;

    always_comb begin
        stateNext  = stateReg;
        playerNext = playerReg;
        shipsNext  = shipsReg;
        redraw     = 1'b0;

        case (stateReg)
            WELCOME: begin
                if (idle && press) begin
                    stateNext  = PLACE;
                    playerNext = '0;
                    shipsNext  = FullFleet;
                    redraw     = 1'b1;
                end
            end
            PLACE: begin
                if (idle && ship_placed && (shipsReg != '0)) begin
                    if (shipsReg == ShipsW'(1)) begin
                        redraw = 1'b1;
                        if (playerReg == LastPlayer) begin
                            stateNext  = PLAY;
                            playerNext = '0;
                            shipsNext  = '0;
                        end else begin
                            playerNext = playerReg + 1'b1;
                            shipsNext  = FullFleet;
                        end
                    end else begin
                        shipsNext = shipsReg - 1'b1;
                    end
                end
            end
            PLAY: begin
                if (idle && shot_fired) begin
                    redraw = 1'b1;
                    if (all_sunk) begin
                        stateNext = OVER;
                    end else if (playerReg == LastPlayer) begin
                        playerNext = '0;
                    end else begin
                        playerNext = playerReg + 1'b1;
                    end
                end
            end
            OVER: begin
                if (idle && press) begin
                    stateNext  = WELCOME;
                    playerNext = '0;
                    shipsNext  = FullFleet;
                    redraw     = 1'b1;
                end
            end
            default: begin
                stateNext = WELCOME;
            end
        endcase

        // redraw only fires from idle, so pend and busy are both clear then.
        pendNext = redraw;
        if (pendReg) begin
            busyNext = 1'b1;
        end else if (busyReg && draw_done) begin
            busyNext = 1'b0;
        end else begin
            busyNext = busyReg;
        end
    end

    always_comb begin
        draw_welcome = 1'b0;
        place_ships  = 1'b0;
        start_game   = 1'b0;
        game_over    = 1'b0;
        case (stateReg)
            WELCOME: draw_welcome = 1'b1;
            PLACE:   place_ships  = 1'b1;
            PLAY:    start_game   = 1'b1;
            OVER:    game_over    = 1'b1;
            default: draw_welcome = 1'b1;
        endcase
    end

    assign player     = playerReg;
    assign ships_left = shipsReg;
    assign draw_req   = drawReqReg;

endmodule

// File: tb/tb_game_phase_fsm.sv
// -----------------------------------------------------------------------------
// tb_game_phase_fsm
// Bench for game_phase_fsm with three players and five ships. Each expected
// redraw (phase, player, ships_left) is queued when the triggering stimulus is
// driven and compared when the DUT raises draw_req. Direct checks cover reset
// values, dropped events and key latency. Works with and without
// KEY_DEBOUNCE_EN (DEBOUNCE_CYCLES = 8).
// -----------------------------------------------------------------------------
module tb_game_phase_fsm;
    import battleship_pkg::*;

    localparam int NP   = 3;
    localparam int NS   = 5;
    localparam int DB   = 8;
    localparam int HOLD = DB + 4;
`ifdef KEY_DEBOUNCE_EN
    localparam int PRESS_LAT = DB + 3;
`else
    localparam int PRESS_LAT = 3;
`endif

    typedef struct {
        int unsigned phase;
        int unsigned player;
        int unsigned ships;
    } exp_t;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic       advance_n;
    logic       ship_placed;
    logic       shot_fired;
    logic       all_sunk;
    logic       draw_done;
    logic       draw_welcome;
    logic       place_ships;
    logic       start_game;
    logic       game_over;
    logic [1:0] player;
    logic [2:0] ships_left;
    logic       draw_req;

    exp_t sbQ[$];
    exp_t monExp;
    int   checks = 0;
    int   errors = 0;
    int   lat;

    game_phase_fsm #(
        .NUM_PLAYERS    (NP),
        .NUM_SHIPS      (NS),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .advance_n   (advance_n),
        .ship_placed (ship_placed),
        .shot_fired  (shot_fired),
        .all_sunk    (all_sunk),
        .draw_done   (draw_done),
        .draw_welcome(draw_welcome),
        .place_ships (place_ships),
        .start_game  (start_game),
        .game_over   (game_over),
        .player      (player),
        .ships_left  (ships_left),
        .draw_req    (draw_req)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not reach its end, checks %0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned flags();
        return {28'd0, game_over, start_game, place_ships, draw_welcome};
    endfunction

    task automatic expectDraw(input int unsigned ph, input int unsigned pl, input int unsigned sh);
        exp_t e;
        e.phase  = ph;
        e.player = pl;
        e.ships  = sh;
        sbQ.push_back(e);
    endtask

    always @(negedge CLOCK_50) begin
        if (resetn === 1'b1 && draw_req === 1'b1) begin
            if (sbQ.size() == 0) begin
                chk("drawReqUnexpected", draw_req, 0);
            end else begin
                monExp = sbQ.pop_front();
                chk("sbPhase", flags(), 32'd1 << monExp.phase);
                chk("sbPlayer", player, monExp.player);
                chk("sbShips", ships_left, monExp.ships);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic drawDone();
        draw_done = 1'b1;
        tick(1);
        draw_done = 1'b0;
        tick(1);
    endtask

    task automatic pressKey();
        advance_n = 1'b0;
        tick(HOLD);
        advance_n = 1'b1;
        tick(HOLD);
    endtask

    task automatic pulseShip();
        ship_placed = 1'b1;
        tick(1);
        ship_placed = 1'b0;
        tick(1);
    endtask

    task automatic pulseShot(input logic sunk);
        all_sunk   = sunk;
        shot_fired = 1'b1;
        tick(1);
        shot_fired = 1'b0;
        all_sunk   = 1'b0;
        tick(1);
    endtask

    initial begin
        resetn      = 1'b0;
        advance_n   = 1'b1;
        ship_placed = 1'b0;
        shot_fired  = 1'b0;
        all_sunk    = 1'b0;
        draw_done   = 1'b0;
        tick(3);

        chk("resetFlags", flags(), 1);
        chk("resetPlayer", player, 0);
        chk("resetShips", ships_left, NS);
        chk("resetDrawReq", draw_req, 0);

        expectDraw(WELCOME, 0, NS);
        resetn = 1'b1;
        tick(1);
        chk("drawReqCycle1", draw_req, 1);
        tick(1);
        chk("drawReqOneCycle", draw_req, 0);

        // no draw_done yet: the press must be dropped
        pressKey();
        chk("pressWhileBusy", flags(), 1);
        drawDone();

`ifdef KEY_DEBOUNCE_EN
        advance_n = 1'b0;
        tick(5);
        advance_n = 1'b1;
        tick(20);
        chk("glitchIgnored", flags(), 1);
`endif

        expectDraw(PLACE, 0, NS);
        advance_n = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            if (place_ships === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk("pressLatency", lat, PRESS_LAT);
        advance_n = 1'b1;
        tick(HOLD);
        chk("placeFlags", flags(), 2);
        chk("placePlayer", player, 0);
        chk("placeShips", ships_left, NS);
        drawDone();

        pulseShot(1'b0);
        chk("shotInPlace", flags(), 2);
        chk("shotInPlaceShips", ships_left, NS);

        for (int p = 0; p < NP; p++) begin
            for (int s = NS; s >= 1; s--) begin
                if (s == 1) begin
                    if (p == NP - 1) expectDraw(PLAY, 0, 0);
                    else             expectDraw(PLACE, p + 1, NS);
                end
                pulseShip();
                if (s > 1) begin
                    chk("shipsLeft", ships_left, s - 1);
                end else if (p < NP - 1) begin
                    chk("nextPlayer", player, p + 1);
                    pulseShip();
                    chk("shipWhileBusy", ships_left, NS);
                    drawDone();
                end
            end
        end
        chk("playFlags", flags(), 4);
        chk("playPlayer", player, 0);
        drawDone();

        for (int i = 1; i <= 3; i++) begin
            expectDraw(PLAY, i % NP, 0);
            pulseShot(1'b0);
            chk("playerTurn", player, i % NP);
            if (i == 1) begin
                pulseShot(1'b0);
                chk("shotWhileBusy", player, 1);
            end
            drawDone();
        end

        expectDraw(PLAY, 1, 0);
        pulseShot(1'b0);
        drawDone();
        expectDraw(OVER, 1, 0);
        pulseShot(1'b1);
        chk("overFlags", flags(), 8);
        chk("winner", player, 1);
        drawDone();

        expectDraw(WELCOME, 0, NS);
        pressKey();
        chk("welcomeAgain", flags(), 1);
        chk("welcomePlayer", player, 0);
        chk("welcomeShips", ships_left, NS);
        drawDone();

        expectDraw(PLACE, 0, NS);
        pressKey();
        drawDone();
        pulseShip();
        chk("midPlaceShips", ships_left, NS - 1);

        resetn = 1'b0;
        #1;
        chk("midResetFlags", flags(), 1);
        chk("midResetPlayer", player, 0);
        chk("midResetShips", ships_left, NS);
        chk("midResetDrawReq", draw_req, 0);
        tick(2);
        expectDraw(WELCOME, 0, NS);
        resetn = 1'b1;
        tick(1);
        chk("drawReqAfterReset", draw_req, 1);
        tick(3);

        chk("sbDrained", sbQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
